// File: rtl/seq_muldiv.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Results land in the hi/lo pair; start/busy/done lets the control unit stall.
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             op_mul,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;
    localparam int RW = WIDTH + 2;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] quo_q;
    logic [RW-1:0]    rem_q;
    logic [CW-1:0]    cnt_q;
    logic             is_mul_q, neg_quo_q, neg_rem_q;

    logic             accept;
    logic [RW-1:0]    m_ext, addend, booth_sum;
    logic [RW-1:0]    d_ext, rem_shift, rem_step;
    logic [WIDTH-1:0] quo_step, rem_corr, rem_fix, quo_fix, a_mag, b_mag;

    assign accept = start && (op_mul ^ op_div);

    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous (sampled on the edge like any other input),
        // and all state uses non-blocking assignment so every register sees
        // pre-edge values regardless of block ordering.
        if (!clear_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case,
        // otherwise a path that skips an assignment infers a latch.
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (accept) state_d = op_mul ? S_MUL : ((b == '0) ? S_DONE : S_DIV);
            S_MUL:   if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DIV:   if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Booth step: the upper part is widened by two bits so +-2M cannot overflow
    // before the arithmetic shift folds it back into WIDTH bits.
    always_comb begin
        m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
        addend = '0;
        case (acc_q[2:0])
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        booth_sum = {{2{acc_q[AW-1]}}, acc_q[AW-1 -: WIDTH]} + addend;

        d_ext     = {2'b00, m_q};
        rem_shift = {rem_q[RW-2:0], quo_q[WIDTH-1]};
        rem_step  = rem_q[RW-1] ? rem_shift + d_ext : rem_shift - d_ext;
        quo_step  = {quo_q[WIDTH-2:0], ~rem_step[RW-1]};

        rem_corr  = rem_q[RW-1] ? rem_q[WIDTH-1:0] + m_q : rem_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -rem_corr : rem_corr;
        quo_fix   = neg_quo_q ? -quo_q : quo_q;

        a_mag     = a[WIDTH-1] ? -a : a;
        b_mag     = b[WIDTH-1] ? -b : b;
    end

    always_ff @(posedge clock) begin
        // NOTE: only the architecturally visible registers are reset; the
        // datapath registers are always loaded at acceptance before use.
        if (!clear_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    div_zero <= 1'b0;
                    is_mul_q <= op_mul;
                    if (op_mul) begin
                        m_q   <= a;
                        acc_q <= {{WIDTH{1'b0}}, b, 1'b0};
                        cnt_q <= CW'(WIDTH / 2);
                    end else begin
                        m_q       <= b_mag;
                        quo_q     <= a_mag;
                        rem_q     <= '0;
                        neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_q <= a[WIDTH-1];
                        cnt_q     <= CW'(WIDTH);
                        if (b == '0) begin
                            div_zero <= 1'b1;
                            quo_q    <= '1;
                            rem_q    <= {2'b00, a};
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= {booth_sum, acc_q[WIDTH:2]};
                    cnt_q <= cnt_q - CW'(1);
                end
                S_DIV: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    quo_q <= quo_fix;
                    rem_q <= {2'b00, rem_fix};
                end
                S_DONE: begin
                    done <= 1'b1;
                    if (is_mul_q) begin
                        hi <= acc_q[AW-1:WIDTH+1];
                        lo <= acc_q[WIDTH:1];
                    end else begin
                        hi <= rem_q[WIDTH-1:0];
                        lo <= quo_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv: expected results come from a behavioural
// model, queued at start and compared when done pulses.
module tb_seq_muldiv;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear_n, start, op_mul, op_div;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_zero;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] held_hi = '0;
    logic [W-1:0] held_lo = '0;

    always #5 clock = ~clock;

    seq_muldiv #(.WIDTH(W)) dut (
        .clock(clock), .clear_n(clear_n), .start(start), .op_mul(op_mul),
        .op_div(op_div), .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .div_zero(div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input string tag, input logic mul, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.tag = tag;
        e.dz  = 1'b0;
        if (mul) begin
            p     = 64'(sx * sy);
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = W / 2 + 1;
        end else if (y == '0) begin
            e.hi  = x;
            e.lo  = '1;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            q     = sx / sy;
            r     = sx % sy;
            p     = 64'(q);
            e.lo  = p[31:0];
            p     = 64'(r);
            e.hi  = p[31:0];
            e.lat = W + 2;
        end
        return e;
    endfunction

    // Runs one operation; optionally re-pulses start with other operands at
    // cycle abuse_at while the unit is busy.
    task automatic run_op(input string tag, input logic mul, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int abuse_at);
        exp_t e;
        int   seen;
        seen = -1;
        @(negedge clock);
        sb.push_back(model(tag, mul, x, y));
        start = 1'b1; op_mul = mul; op_div = !mul; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0; op_mul = 1'b0; op_div = 1'b0;
        check($sformatf("%s busy@0", tag), 64'(busy), 64'(1));
        check($sformatf("%s done@0", tag), 64'(done), 64'(0));
        if (sb[sb.size()-1].dz == 1'b0)
            check($sformatf("%s div_zero@0", tag), 64'(div_zero), 64'(0));
        for (int n = 1; n <= W + 8; n++) begin
            if (n == abuse_at) begin
                start = 1'b1; op_mul = 1'b1; op_div = 1'b0; a = 32'd3; b = 32'd5;
            end else begin
                start = 1'b0; op_mul = 1'b0; op_div = 1'b0;
            end
            @(posedge clock); #1;
            if (done) begin
                seen = n;
                break;
            end
            check($sformatf("%s busy@%0d", tag, n), 64'(busy), 64'(1));
            check($sformatf("%s hold@%0d", tag, n), {hi, lo}, {held_hi, held_lo});
        end
        start = 1'b0; op_mul = 1'b0; op_div = 1'b0;
        e = sb.pop_front();
        check($sformatf("%s latency", e.tag), 64'(seen), 64'(e.lat));
        check($sformatf("%s hi", e.tag), 64'(hi), 64'(e.hi));
        check($sformatf("%s lo", e.tag), 64'(lo), 64'(e.lo));
        check($sformatf("%s div_zero", e.tag), 64'(div_zero), 64'(e.dz));
        check($sformatf("%s busy_after", e.tag), 64'(busy), 64'(0));
        held_hi = e.hi;
        held_lo = e.lo;
    endtask

    task automatic bad_start(input string tag, input logic m, input logic d);
        @(negedge clock);
        start = 1'b1; op_mul = m; op_div = d; a = 32'd9; b = 32'd9;
        @(posedge clock); #1;
        start = 1'b0; op_mul = 1'b0; op_div = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("%s busy@%0d", tag, n), 64'(busy), 64'(0));
            check($sformatf("%s done@%0d", tag, n), 64'(done), 64'(0));
            @(posedge clock); #1;
        end
        check($sformatf("%s hold", tag), {hi, lo}, {held_hi, held_lo});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        clear_n = 1'b0; start = 1'b0; op_mul = 1'b0; op_div = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        @(negedge clock);
        clear_n = 1'b1;

        run_op("mul 7*-3", 1'b1, 32'd7, 32'hFFFF_FFFD, -1);
        run_op("mul MIN*MIN", 1'b1, 32'h8000_0000, 32'h8000_0000, -1);
        run_op("mul b2b", 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, -1);
        run_op("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("div 7/-2", 1'b0, 32'd7, 32'hFFFF_FFFE, -1);
        run_op("div by zero", 1'b0, 32'h1234_5678, 32'd0, -1);
        run_op("div MIN/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("mul -1*-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("div 100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9, -1);

        bad_start("both selects", 1'b1, 1'b1);
        bad_start("no select", 1'b0, 1'b0);

        run_op("div abused", 1'b0, 32'hFFFF_FC18, 32'd37, 10);

        // Abandon a multiply with reset at edge 10.
        @(negedge clock);
        start = 1'b1; op_mul = 1'b1; op_div = 1'b0; a = 32'd1234; b = 32'd5678;
        @(posedge clock); #1;
        start = 1'b0; op_mul = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        clear_n = 1'b0;
        @(posedge clock); #1;
        check("midreset hi", 64'(hi), 64'(0));
        check("midreset lo", 64'(lo), 64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset done", 64'(done), 64'(0));
        @(negedge clock);
        clear_n = 1'b1;
        held_hi = '0;
        held_lo = '0;
        saw_done = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clock); #1;
            if (done) saw_done = 1'b1;
        end
        check("midreset no done", 64'(saw_done), 64'(0));
        check("midreset idle", 64'(busy), 64'(0));

        run_op("mul 3*4", 1'b1, 32'd3, 32'd4, -1);

        check("scoreboard empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Multi-cycle signed multiply/divide unit that supersedes the combinational MUL/DIV paths of the datapath ALU. Operand width is a parameter.
- Multiply uses radix-4 Booth (bit-pair recoding). Divide uses non-restoring division on magnitudes, followed by a sign fix-up.
- Results go to the HI/LO register pair. A start/busy/done handshake lets the control unit stall while the operation runs.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
clear_n  in  1  synchronous active-low reset, sampled on the rising edge of clock.
start  in  1  request a new operation; sampled only in IDLE.
op_mul  in  1  select signed multiply.
op_div  in  1  select signed divide.
a  in  WIDTH  multiplicand or dividend.
b  in  WIDTH  multiplier or divisor.
hi  out  WIDTH  product upper half, or remainder.
lo  out  WIDTH  product lower half, or quotient.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse when hi/lo become valid.
div_zero  out  1  set when the last divide had b==0; cleared by the next accepted start.

Behaviour:
- Reset: when clear_n=0 at an edge, go to IDLE and set hi=0, lo=0, busy=0, done=0, div_zero=0. This applies in any state; an operation in flight is abandoned and produces no done.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, start acceptance:
  - start=1 with exactly one of op_mul/op_div high: latch a and b, clear div_zero, set busy=1.
  - start=1 with neither or both op selects high: ignored, stay in IDLE.
  - start while busy: ignored; latched operands are not disturbed.
- MUL:
  - Accumulator is 2*WIDTH+1 bits (product, multiplier, guard bit).
  - Each cycle, recode one bit-triplet to a digit in {-2,-1,0,+1,+2}. Add or subtract 0, M or 2M (M sign-extended) into the upper part, then arithmetic-shift right by 2.
  - Runs WIDTH/2 cycles, then goes to DONE.
  - Product is exact signed 2*WIDTH-bit.
- DIV:
  - At acceptance, b==0 goes straight to DONE with hi=a, lo=all ones, div_zero=1.
  - Otherwise run non-restoring division on |a| and |b|, one quotient bit per cycle, for WIDTH cycles, then go to FIX.
  - FIX (one cycle):
    - If the partial remainder is negative, add |b| back.
    - Negate the quotient if sign(a) differs from sign(b).
    - Negate the remainder if a is negative.
  - Then go to DONE.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case MIN / -1 gives lo=MIN (wraps) and hi=0, with no flag.
- DONE (one cycle): register hi/lo, pulse done=1, clear busy, return to IDLE.
  - start is accepted again in the cycle after done; back-to-back operations are allowed.
- Latency, counting the accepting edge as edge 0:
  - Multiply: done high after edge WIDTH/2+1.
  - Divide: done high after edge WIDTH+2.
  - Divide by zero: done high after edge 1.
- Output hold: hi/lo keep their values from the last completed operation until the next done or reset. They never show intermediate values.
- Iteration counter: ceil(log2(WIDTH))+1 bits. It must not wrap during an operation.

Test Plan:
WIDTH=32 throughout.
1. Mixed-sign multiply: a=7, b=0xFFFFFFFD (-3), op_mul -> done after edge 17; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for edges 0..16.
2. MIN × MIN: a=b=0x80000000, op_mul -> hi=0x40000000, lo=0x00000000. Back-to-back: a=0x0000FFFF, b=0x0000FFFF started in the cycle after done -> hi=0, lo=0xFFFE0001.
3. Signed divide: a=0xFFFFFFF9 (-7), b=2, op_div -> done after edge 34; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
4. Divide by zero and overflow:
   - a=0x12345678, b=0 -> done after edge 1; hi=0x12345678, lo=0xFFFFFFFF, div_zero=1.
   - Next op a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
5. Handshake abuse:
   - start with op_mul=op_div=1 -> no busy, no done.
   - start pulsed mid-divide with new operands -> ignored; result matches the original operands.
6. Reset mid-operation: clear_n=0 at edge 10 of a multiply -> hi=lo=0, busy=0, and no done pulse. A new multiply 3×4 started afterwards gives lo=12, hi=0.
